// File: rtl/btb_pkg.sv
// btb_pkg: shared entry layout, counter constants and PC field helpers for the BTB.
package btb_pkg;
  localparam int TAG_W = 28;
  localparam logic [1:0] CTR_ALLOC = 2'd2;
  localparam logic [1:0] CTR_MAX = 2'd3;
  typedef struct packed {
    logic valid;
    logic [TAG_W-1:0] tag;
    logic [31:0] target;
    logic [1:0] ctr;
  } btb_entry_t;
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction
  // Tag is held at the widest size (smallest table); narrower tags zero-extend.
  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc, input int idx_w);
    return TAG_W'(pc >> (idx_w + 2));
  endfunction
endpackage

// File: rtl/btb_sat_ctr.sv
// btb_sat_ctr: 2-bit saturating up/down counter next-state function.
module btb_sat_ctr
  import btb_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       up,
  output logic [1:0] ctr_nxt
);
  always_comb ctr_nxt = up ? ((ctr == CTR_MAX) ? ctr : ctr + 2'd1)
                           : ((ctr == 2'd0) ? ctr : ctr - 2'd1);
endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with combinational lookup, execute-stage
// training and a registered one-cycle misprediction redirect.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int ENTRIES = 64,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_pc,
  output logic        hit,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_hit,
  input  logic [31:0] upd_pred_target,
  output logic        redirect,
  output logic [31:0] redirect_pc
);
  btb_entry_t tbl_q [ENTRIES];
  btb_entry_t f_ent, u_ent, wr_ent_d;
  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] u_tag;
  logic u_present, wr_en, mispredict;
  logic [1:0] ctr_nxt;
  logic redirect_d, redirect_q;
  logic [31:0] redirect_pc_d, redirect_pc_q;

  always_comb begin
    f_idx = IDX_W'(pc_index(fetch_pc, IDX_W));
    f_ent = tbl_q[f_idx];
    hit = f_ent.valid && (f_ent.tag == pc_tag(fetch_pc, IDX_W)) && f_ent.ctr[1];
    pred_target = hit ? f_ent.target : '0;
  end

  btb_sat_ctr u_ctr (.ctr(u_ent.ctr), .up(upd_taken), .ctr_nxt(ctr_nxt));

  always_comb begin
    u_idx = IDX_W'(pc_index(upd_pc, IDX_W));
    u_tag = pc_tag(upd_pc, IDX_W);
    u_ent = tbl_q[u_idx];
    u_present = u_ent.valid && (u_ent.tag == u_tag);
    wr_en = upd_valid && (u_present || upd_taken);
    wr_ent_d.valid = 1'b1;
    wr_ent_d.tag = u_tag;
    wr_ent_d.target = upd_taken ? upd_target : u_ent.target;
    wr_ent_d.ctr = u_present ? ctr_nxt : CTR_ALLOC;
    mispredict = upd_valid && ((upd_taken != upd_pred_hit) ||
                 (upd_taken && upd_pred_hit && (upd_target != upd_pred_target)));
    redirect_d = mispredict;
    redirect_pc_d = !mispredict ? redirect_pc_q : upd_taken ? upd_target : upd_pc + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= '0;
      redirect_q <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      if (wr_en) tbl_q[u_idx] <= wr_ent_d;
      redirect_q <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign redirect = redirect_q;
  assign redirect_pc = redirect_pc_q;
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: table-driven lookup/training vectors with a redirect
// scoreboard, plus hand-written idle and asynchronous-reset sequences.
module tb_branch_target_buffer;
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] fetch_pc;
  logic hit;
  logic [31:0] pred_target;
  logic upd_valid;
  logic [31:0] upd_pc;
  logic upd_taken;
  logic [31:0] upd_target;
  logic upd_pred_hit;
  logic [31:0] upd_pred_target;
  logic redirect;
  logic [31:0] redirect_pc;

  branch_target_buffer #(.ENTRIES(64)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .hit(hit), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_hit(upd_pred_hit), .upd_pred_target(upd_pred_target),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic uv; logic [31:0] pc; logic tk; logic [31:0] tgt; logic ph; logic [31:0] pt;
    logic [31:0] fpc; logic eh; logic [31:0] et; logic er; logic [31:0] erpc;
  } vec_t;
  typedef struct {logic r; logic [31:0] pc; int id;} exp_t;

  vec_t vecs[23];
  exp_t sb[$];
  int total = 0;
  int bad = 0;

  function automatic vec_t v(logic uv, logic [31:0] pc, logic tk, logic [31:0] tgt, logic ph,
                             logic [31:0] pt, logic [31:0] fpc, logic eh, logic [31:0] et,
                             logic er, logic [31:0] erpc);
    vec_t r;
    r.uv = uv; r.pc = pc; r.tk = tk; r.tgt = tgt; r.ph = ph; r.pt = pt;
    r.fpc = fpc; r.eh = eh; r.et = et; r.er = er; r.erpc = erpc;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step(vec_t t, int id);
    exp_t e;
    @(negedge clk);
    upd_valid = t.uv; upd_pc = t.pc; upd_taken = t.tk; upd_target = t.tgt;
    upd_pred_hit = t.ph; upd_pred_target = t.pt; fetch_pc = t.fpc;
    #1;
    chk($sformatf("v%0d hit", id), {31'd0, hit}, {31'd0, t.eh});
    chk($sformatf("v%0d pred_target", id), pred_target, t.et);
    sb.push_back('{r: t.er, pc: t.erpc, id: id});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("v%0d redirect", e.id), {31'd0, redirect}, {31'd0, e.r});
    chk($sformatf("v%0d redirect_pc", e.id), redirect_pc, e.pc);
  endtask

  initial begin
    vecs[0]  = v(0, 0, 0, 0, 0, 0, 32'h100, 0, 0, 0, 0);
    vecs[1]  = v(1, 32'h100, 1, 32'h200, 0, 0, 32'h100, 0, 0, 1, 32'h200);
    vecs[2]  = v(0, 0, 0, 0, 0, 0, 32'h100, 1, 32'h200, 0, 32'h200);
    vecs[3]  = v(1, 32'h100, 0, 0, 1, 32'h200, 32'h100, 1, 32'h200, 1, 32'h104);
    vecs[4]  = v(0, 0, 0, 0, 0, 0, 32'h100, 0, 0, 0, 32'h104);
    vecs[5]  = v(1, 32'h100, 0, 0, 1, 32'h200, 32'h104, 0, 0, 1, 32'h104);
    vecs[6]  = v(1, 32'h100, 1, 32'h200, 0, 0, 32'h100, 0, 0, 1, 32'h200);
    vecs[7]  = v(1, 32'h100, 1, 32'h200, 0, 0, 32'h100, 0, 0, 1, 32'h200);
    vecs[8]  = v(0, 0, 0, 0, 0, 0, 32'h100, 1, 32'h200, 0, 32'h200);
    vecs[9]  = v(1, 32'h100, 1, 32'h200, 1, 32'h200, 32'h100, 1, 32'h200, 0, 32'h200);
    vecs[10] = v(1, 32'h100, 0, 0, 1, 32'h200, 32'h100, 1, 32'h200, 1, 32'h104);
    vecs[11] = v(0, 0, 0, 0, 0, 0, 32'h100, 1, 32'h200, 0, 32'h104);
    vecs[12] = v(1, 32'h140, 0, 32'h900, 0, 0, 32'h140, 0, 0, 0, 32'h104);
    vecs[13] = v(0, 0, 0, 0, 0, 0, 32'h140, 0, 0, 0, 32'h104);
    vecs[14] = v(1, 32'h1100, 1, 32'h500, 0, 0, 32'h1100, 0, 0, 1, 32'h500);
    vecs[15] = v(0, 0, 0, 0, 0, 0, 32'h100, 0, 0, 0, 32'h500);
    vecs[16] = v(0, 0, 0, 0, 0, 0, 32'h1100, 1, 32'h500, 0, 32'h500);
    vecs[17] = v(1, 32'h100, 1, 32'h200, 0, 0, 32'h1100, 1, 32'h500, 1, 32'h200);
    vecs[18] = v(1, 32'h100, 1, 32'h300, 1, 32'h200, 32'h100, 1, 32'h200, 1, 32'h300);
    vecs[19] = v(0, 0, 0, 0, 0, 0, 32'h100, 1, 32'h300, 0, 32'h300);
    vecs[20] = v(0, 0, 0, 0, 0, 0, 32'h102, 1, 32'h300, 0, 32'h300);
    vecs[21] = v(1, 32'hFFFFFFFC, 0, 0, 1, 32'h1234, 32'h0, 0, 0, 1, 32'h0);
    vecs[22] = v(0, 0, 0, 0, 0, 0, 32'h1100, 0, 0, 0, 32'h0);

    rst_n = 1'b0; fetch_pc = 32'h100; upd_valid = 0; upd_pc = 0; upd_taken = 0;
    upd_target = 0; upd_pred_hit = 0; upd_pred_target = 0;
    #1;
    chk("reset hit", {31'd0, hit}, 32'd0);
    chk("reset pred_target", pred_target, 32'd0);
    chk("reset redirect", {31'd0, redirect}, 32'd0);
    chk("reset redirect_pc", redirect_pc, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle%0d redirect", i), {31'd0, redirect}, 32'd0);
    end

    for (int i = 0; i < 23; i++) step(vecs[i], i);

    // Allocate 0x200 (index 0) with a mispredict, then reset mid-cycle with an update pending.
    @(negedge clk);
    upd_valid = 1; upd_pc = 32'h200; upd_taken = 1; upd_target = 32'h700;
    upd_pred_hit = 0; upd_pred_target = 0; fetch_pc = 32'h200;
    @(posedge clk);
    #1;
    chk("pre-rst redirect", {31'd0, redirect}, 32'd1);
    chk("pre-rst redirect_pc", redirect_pc, 32'h700);
    chk("pre-rst hit", {31'd0, hit}, 32'd1);
    chk("pre-rst pred_target", pred_target, 32'h700);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst redirect", {31'd0, redirect}, 32'd0);
    chk("async rst redirect_pc", redirect_pc, 32'd0);
    chk("async rst hit", {31'd0, hit}, 32'd0);
    chk("async rst pred_target", pred_target, 32'd0);
    @(posedge clk);
    @(negedge clk);
    upd_valid = 0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst redirect", {31'd0, redirect}, 32'd0);
    chk("post-rst hit", {31'd0, hit}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
